// File: rtl/data_ram_if.sv
// CPU memory-stage port of the data RAM: load/store strobes, byte address,
// store data and combinational load data.
interface data_ram_if;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [7:0]  mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;

  modport master (
    output mem_read_i,
    output mem_write_i,
    output mem_addr_i,
    output mem_data_i,
    input  mem_data_o
  );

  modport slave (
    input  mem_read_i,
    input  mem_write_i,
    input  mem_addr_i,
    input  mem_data_i,
    output mem_data_o
  );
endinterface

// File: rtl/data_ram.sv
// 256-byte register-based data RAM: unaligned little-endian 32-bit words with
// mod-256 wrap, zero-latency loads, single-cycle stores, saturating access counters.
module data_ram #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  data_ram_if.slave        bus,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic [CNT_W-1:0] wr_cnt_o,
  output logic             err_o
);

  logic [7:0] mem [256];
  logic [7:0] lane_addr [4];
  logic       rd_en;
  logic       wr_en;

  // Reset masks both strobes so nothing is written, counted or flagged.
  assign rd_en = bus.mem_read_i  && !rst;
  assign wr_en = bus.mem_write_i && !rst;

  // Byte lane k lives at addr+k; the 8-bit add gives the mod-256 wrap.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = bus.mem_addr_i + 8'(k);
    end
  end

  // NOTE: the storage is cleared on reset, so it must be flops rather than an
  // inferred RAM macro; non-blocking writes also make a same-cycle read see old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        mem[lane_addr[k]] <= bus.mem_data_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    bus.mem_data_o = '0;
    if (rd_en) begin
      for (int k = 0; k < 4; k++) begin
        bus.mem_data_o[8*k +: 8] = mem[lane_addr[k]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_o <= '0;
    end else if (rd_en && (rd_cnt_o != '1)) begin
      rd_cnt_o <= rd_cnt_o + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_o <= '0;
    end else if (wr_en && (wr_cnt_o != '1)) begin
      wr_cnt_o <= wr_cnt_o + CNT_W'(1);
    end
  end

  // Sticky until reset: a load and store issued together is a pipeline hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (rd_en && wr_en) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 The module SHALL have one parameter: CNT_W, default 16, width of the access counters.
REQ-002 The module SHALL have a single clock, clk: input, 1 bit, rising-edge clock for all state.
REQ-003 The module SHALL have a single reset, rst: input, 1 bit; it SHALL be synchronous and active-high.
REQ-004 mem_read_i  input  1  read strobe from the CPU memory stage.
REQ-005 mem_write_i  input  1  write strobe from the CPU memory stage.
REQ-006 mem_addr_i  input  8  byte address of the word's least significant byte.
REQ-007 mem_data_i  input  32  store data.
REQ-008 mem_data_o  output  32  load data returned to the CPU memory stage.
REQ-009 rd_cnt_o  output  CNT_W  count of accepted reads.
REQ-010 wr_cnt_o  output  CNT_W  count of accepted writes.
REQ-011 err_o  output  1  sticky flag for a read and write in the same cycle.

Function
REQ-012 Storage SHALL be 256 bytes, indexed 0..255, held in registers.
REQ-013 Words SHALL be little-endian: byte k of the word (bits 8k+7:8k) maps to address (mem_addr_i+k) mod 256, for k = 0..3.
REQ-014 Address wrap SHALL be mod 256 with no alignment requirement; address 0xFE covers bytes FE, FF, 00 and 01.
REQ-015 Reads SHALL be combinational.
- When mem_read_i=1 and rst=0, mem_data_o SHALL present the 4 addressed bytes in the same cycle (zero-latency, as the CPU memory stage requires).
- Otherwise mem_data_o SHALL be 32'h0.
REQ-016 Writes SHALL be single-cycle: when mem_write_i=1 and rst=0, the 4 addressed bytes SHALL update at the rising edge, with data visible from the next cycle.
REQ-017 Read-during-write at any address in the same cycle SHALL return pre-edge (old) contents.
REQ-018 When mem_read_i=1 and mem_write_i=1 in the same cycle:
- the write SHALL be performed;
- the read data SHALL be old contents;
- both counters SHALL increment;
- err_o SHALL be set at the edge and SHALL stay 1 until reset.
REQ-019 Counters:
- rd_cnt_o SHALL increment by 1 at each edge with mem_read_i=1.
- wr_cnt_o SHALL increment by 1 at each edge with mem_write_i=1.
- Both SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-020 Strobes that are low SHALL leave memory and counters unchanged; address and data values are then don't-care.
REQ-021 Overlapping consecutive writes (e.g. address 0x10 then 0x12) SHALL resolve byte-wise, with the later write winning on shared bytes.

Reset
REQ-022 While rst=1 at a rising edge:
- all 256 bytes SHALL clear to 8'h00;
- rd_cnt_o and wr_cnt_o SHALL clear to 0;
- err_o SHALL clear to 0.
REQ-023 While rst=1, mem_data_o SHALL be 32'h0, and strobes SHALL be ignored (no write, no count, no error).
REQ-024 Reset asserted in the same cycle as a write SHALL win: memory reads back 0 after reset deasserts.

Verification
REQ-025 Basic store/load: reset 1 cycle; write 32'h11223344 at addr 0x20; then read 0x20 -> mem_data_o=32'h11223344; read 0x21 -> 32'h00112233; wr_cnt_o=1, rd_cnt_o=2, err_o=0.
REQ-026 Wrap-around: write 32'hAABBCCDD at 0xFE; read 0x00 -> 32'h0000AABB; read 0xFC -> 32'hCCDD0000.
REQ-027 Collision: preload 0x40=32'h5; in one cycle read=1, write=1, addr 0x40, data 32'h9 -> mem_data_o=32'h5 that cycle, 32'h9 on next read; err_o=1 from the next cycle and through 10 further idle cycles.
REQ-028 Reset mid-operation: write 32'hFFFFFFFF at 0x80; assert rst together with a write of 32'h1234 at 0x80; deassert; read 0x80 -> 32'h0; counters=0; err_o=0.
REQ-029 Counter saturation (CNT_W=4): 20 consecutive reads -> rd_cnt_o=15 and stays 15; wr_cnt_o=0.
REQ-030 Idle output: mem_read_i=0 at any address with non-zero contents -> mem_data_o=32'h0.
